// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, funct codes, ALU control codes and the control bundle.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned REG_A_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;

    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic             reg_write;
        logic             memto_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic             branch;
        logic             jump;
        logic [ALU_W-1:0] alu_control;
    } ctrl_t;

    // Main control plus ALU decoder; unrecognised opcodes decode to a NOP.
    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_control = ALU_ADD;
                    FN_SUB:  c.alu_control = ALU_SUB;
                    FN_AND:  c.alu_control = ALU_AND;
                    FN_OR:   c.alu_control = ALU_OR;
                    FN_SLT:  c.alu_control = ALU_SLT;
                    default: c.alu_control = ALU_ADD;
                endcase
            end
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.memto_reg   = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write-through, one write port, $0 hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned regs  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_A_W-1:0]   ra1,
    input  logic [REG_A_W-1:0]   ra2,
    output logic [width-1:0]     rd1,
    output logic [width-1:0]     rd2,
    input  logic                 we,
    input  logic [REG_A_W-1:0]   wa,
    input  logic [width-1:0]     wd
);

    logic [width-1:0] mem [regs];
    logic             wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(regs); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // Same-cycle writeback is bypassed so decode sees the value being written.
    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (wr_en && (wa == ra1)) rd1 = wd;
        if (wr_en && (wa == ra2)) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, register read, early beq resolution and the ID/EX register.
module decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned regs  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     InstrD,
    input  logic [width-1:0]     PCPlus4D,
    input  logic                 RegWriteW,
    input  logic [REG_A_W-1:0]   WriteRegW,
    input  logic [width-1:0]     ResultW,
    input  logic [width-1:0]     ALUOutM,
    input  logic                 ForwardAD,
    input  logic                 ForwardBD,
    input  logic                 FlushE,
    output logic                 PCSrcD,
    output logic                 JumpD,
    output logic [width-1:0]     PCBranchD,
    output logic                 BranchD,
    output logic [REG_A_W-1:0]   RsD,
    output logic [REG_A_W-1:0]   RtD,
    output logic                 RegWriteE,
    output logic                 MemtoRegE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 RegDstE,
    output logic [ALU_W-1:0]     ALUControlE,
    output logic [width-1:0]     RD1E,
    output logic [width-1:0]     RD2E,
    output logic [width-1:0]     SignImmE,
    output logic [REG_A_W-1:0]   RsE,
    output logic [REG_A_W-1:0]   RtE,
    output logic [REG_A_W-1:0]   RdE
);

    ctrl_t              ctrl;
    logic [width-1:0]   rd1;
    logic [width-1:0]   rd2;
    logic [width-1:0]   sign_imm;
    logic [width-1:0]   cmp_a;
    logic [width-1:0]   cmp_b;
    logic [REG_A_W-1:0] rd_field;
    logic               unused_shamt;

    assign ctrl         = decode_ctrl(InstrD[31:26], InstrD[5:0]);
    assign RsD          = InstrD[25:21];
    assign RtD          = InstrD[20:16];
    assign rd_field     = InstrD[15:11];
    assign unused_shamt = ^InstrD[10:6];
    assign sign_imm     = {{(width-16){InstrD[15]}}, InstrD[15:0]};

    reg_file #(
        .width (width),
        .regs  (regs)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (RsD),
        .ra2   (RtD),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (RegWriteW),
        .wa    (WriteRegW),
        .wd    (ResultW)
    );

    // Early branch resolution with the memory-stage result forwarded in.
    assign cmp_a     = ForwardAD ? ALUOutM : rd1;
    assign cmp_b     = ForwardBD ? ALUOutM : rd2;
    assign BranchD   = ctrl.branch;
    assign JumpD     = ctrl.jump;
    assign PCSrcD    = ctrl.branch && (cmp_a == cmp_b);
    assign PCBranchD = PCPlus4D + (sign_imm << 2);

    // ID/EX pipeline register; a flush inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
        end else begin
            RegWriteE   <= ctrl.reg_write;
            MemtoRegE   <= ctrl.memto_reg;
            MemWriteE   <= ctrl.mem_write;
            ALUSrcE     <= ctrl.alu_src;
            RegDstE     <= ctrl.reg_dst;
            ALUControlE <= ctrl.alu_control;
            RD1E        <= rd1;
            RD2E        <= rd2;
            SignImmE    <= sign_imm;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= rd_field;
        end
    end

endmodule
